// File: rtl/csr_spmv_pkg.sv
// Shared definitions for the CSR sparse-matrix x dense-block multiply engine.
//   state_t : engine sequencing states
//   MAC_LAT : cycles from issuing a nonzero address until its product is in the accumulator
package csr_spmv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RP0,
    RPN,
    STREAM,
    DRAIN,
    EMIT,
    FIN
  } state_t;

  localparam int MAC_LAT = 4;

endpackage

// File: rtl/csr_spmv_engine_mac_lane.sv
// One MAC lane: registered signed multiply followed by a load/accumulate register.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   a, b        signed DW operands (nonzero value, dense entry)
//   acc_en      the registered product belongs to a live nonzero
//   acc_first   that nonzero is the first of its row: load instead of add
//   acc_clr     force the accumulator to zero (empty row)
//   acc         running row sum, ACC_W bits, wraps modulo 2**ACC_W
module spmv_mac_lane
  import csr_spmv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ACC_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic             acc_en,
  input  logic             acc_first,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;

  // The product register runs every cycle; only tagged products reach the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prod <= '0;
    else      prod <= $signed(a) * $signed(b);
  end

  // Narrow accumulators keep the low bits of the product, which is the same as wrapping.
  if (ACC_W >= 2*DW) begin : g_sext
    assign prod_ext = ACC_W'(prod);
  end else begin : g_trunc
    assign prod_ext = prod[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           acc_q <= '0;
    else if (acc_clr)   acc_q <= '0;
    else if (acc_en)    acc_q <= acc_first ? prod_ext : acc_q + prod_ext;
  end

  assign acc = acc_q;

endmodule

// File: rtl/csr_spmv_engine.sv
// CSR sparse-matrix x dense-block multiply engine. Walks the row pointers, streams
// nonzeros and column indices, fetches LANES dense columns per column index and emits
// one LANES-wide row sum per row on a ready/valid port.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   start, n_rows              begin a job of n_rows rows (ignored while busy)
//   busy, done, err            job in progress, end-of-job pulse, sticky bad row pointer
//   rp_addr / rp_data          row-pointer memory, 1-cycle read latency
//   nz_addr / val_data,col_data nonzero memory, 1-cycle read latency
//   x_addr / x_data            dense vector memory, x_addr is col_data passed through
//   y_valid,y_ready,y_row,y_data,y_empty  result port
module csr_spmv_engine
  import csr_spmv_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int ACC_W = 64,
  parameter int NZ_AW = 14,
  parameter int RP_AW = 10,
  parameter int X_AW  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [RP_AW-1:0]       n_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [RP_AW-1:0]       rp_addr,
  input  logic [NZ_AW:0]         rp_data,
  output logic [NZ_AW-1:0]       nz_addr,
  input  logic [DW-1:0]          val_data,
  input  logic [X_AW-1:0]        col_data,
  output logic [X_AW-1:0]        x_addr,
  input  logic [LANES*DW-1:0]    x_data,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [RP_AW-1:0]       y_row,
  output logic [LANES*ACC_W-1:0] y_data,
  output logic                   y_empty
);

  state_t               state, state_nx;
  logic [RP_AW-1:0]     n_rows_q;
  logic [RP_AW-1:0]     row;
  logic [NZ_AW:0]       row_start;
  logic [NZ_AW:0]       row_end;
  logic [NZ_AW:0]       nz_ptr;
  logic                 rp_pend;
  logic                 first_q;
  logic                 empty_q;
  logic [DW-1:0]        val_q;
  logic [MAC_LAT-2:0]   pipe_v;
  logic [MAC_LAT-2:0]   pipe_first;
  logic                 issue;
  logic                 rp_ok;
  logic                 row_has_nz;
  logic                 last_issue;
  logic                 last_row;
  logic                 lane_clr;

  // A row-pointer read takes two cycles in RP0/RPN: present the address, then use the data.
  assign rp_ok      = rp_pend;
  assign row_has_nz = rp_data > row_start;
  assign issue      = (state == STREAM);
  assign last_issue = (nz_ptr + (NZ_AW+1)'(1)) == row_end;
  assign last_row   = (row + RP_AW'(1)) == n_rows_q;
  assign lane_clr   = (state == RPN) && rp_ok && !row_has_nz;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = (n_rows == '0) ? FIN : RP0;
      RP0:    if (rp_ok) state_nx = RPN;
      RPN:    if (rp_ok) state_nx = row_has_nz ? STREAM : EMIT;
      STREAM: if (last_issue) state_nx = DRAIN;
      DRAIN:  if (pipe_v == '0) state_nx = EMIT;
      EMIT:   if (y_ready) state_nx = last_row ? FIN : RPN;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Per-nonzero valid/first tags travel alongside the memory and multiply latency so the
  // lanes know which products to fold in and which one starts a fresh row sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v     <= '0;
      pipe_first <= '0;
      val_q      <= '0;
    end else begin
      pipe_v     <= {pipe_v[MAC_LAT-3:0], issue};
      pipe_first <= {pipe_first[MAC_LAT-3:0], issue && first_q};
      val_q      <= val_data;
    end
  end

  // Row bookkeeping. The next row's start is always the current row's end pointer,
  // even when that pointer went backwards and the row was flagged as an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_rows_q  <= '0;
      row       <= '0;
      row_start <= '0;
      row_end   <= '0;
      nz_ptr    <= '0;
      rp_pend   <= 1'b0;
      first_q   <= 1'b0;
      empty_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          n_rows_q <= n_rows;
          row      <= '0;
          err      <= 1'b0;
          busy     <= 1'b1;
          rp_pend  <= 1'b0;
          empty_q  <= 1'b0;
        end
        RP0: begin
          rp_pend <= ~rp_pend;
          if (rp_ok) row_start <= rp_data;
        end
        RPN: begin
          rp_pend <= ~rp_pend;
          if (rp_ok) begin
            nz_ptr    <= row_start;
            row_end   <= rp_data;
            row_start <= rp_data;
            first_q   <= 1'b1;
            empty_q   <= !row_has_nz;
            if (rp_data < row_start) err <= 1'b1;
          end
        end
        STREAM: begin
          nz_ptr  <= nz_ptr + (NZ_AW+1)'(1);
          first_q <= 1'b0;
        end
        EMIT: if (y_ready) row <= row + RP_AW'(1);
        FIN:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    spmv_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .a         (val_q),
      .b         (x_data[k*DW +: DW]),
      .acc_en    (pipe_v[MAC_LAT-2]),
      .acc_first (pipe_first[MAC_LAT-2]),
      .acc_clr   (lane_clr),
      .acc       (y_data[k*ACC_W +: ACC_W])
    );
  end

  assign rp_addr = (state == RPN) ? row + RP_AW'(1) : '0;
  assign nz_addr = nz_ptr[NZ_AW-1:0];
  assign x_addr  = col_data;
  assign y_valid = (state == EMIT);
  assign y_row   = row;
  assign y_empty = empty_q;

endmodule
